paddsb_seq: RTL and testbench
=============================

Name: paddsb_seq

Overview:
Multi-cycle saturating parallel sub-word adder (PADDSB) for the 16-bit datapath ALU. It is the lane-splitting counterpart of the byte-reduction unit. Each operand is split into four signed 4-bit lanes. The unit produces four independent saturated nibble sums, using one shared 4-bit CLA stage over four cycles. It sits beside the ALU, and the EX stage drives it through a start/done handshake.

Parameters:
LANES, 4, number of 4-bit lanes per 16-bit operand; fixed at 4 for this ISA.
LANE_W, 4, lane width in bits; fixed at 4.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
flush  input  1  synchronous abort from pipeline flush/stall logic
rs  input  16  operand A, four signed nibbles, lane i = rs[4i+3:4i]
rt  input  16  operand B, same lane layout
busy  output  1  high whenever state is not IDLE
done  output  1  one-cycle pulse; rd is valid in this cycle
sat  output  1  OR of per-lane saturation events for the current/last op
rd  output  16  packed lane results

Behaviour:
- Reset is asynchronous on rst_n low and applies at any time, including mid-operation.
  - state=IDLE, lane counter=0, busy=0, done=0, sat=0, rd=16'h0000, operand registers=0.
  - On rst_n release the unit waits in IDLE. No partial result is retained.
- FSM states: IDLE, CALC, DONE.
  - IDLE: when start=1 and flush=0 at a rising edge (edge E0):
    - capture rs and rt into internal operand registers;
    - clear rd and sat, set lane=0, go to CALC.
    - After capture, the rs/rt inputs are don't-care.
  - CALC: at each edge E1..E4, compute lane `lane` from the captured operands:
    - write the 4-bit result into rd[4*lane+3:4*lane];
    - OR the lane saturation flag into sat;
    - increment lane.
    - At E4 (lane==3) go to DONE.
  - DONE: done=1 for exactly one cycle; next edge goes to IDLE.
- Latency: done is high in the cycle following E4, i.e. 5 cycles after the start edge. Throughput is one op per 6 cycles; start may be reasserted in the IDLE cycle right after DONE.
- start while busy=1 is ignored; no queueing.
- flush=1 at any edge while in CALC or DONE forces IDLE with lane=0. done is not asserted.
  - rd and sat keep whatever partial value they held; the consumer must ignore them.
  - flush in IDLE has priority over start: the request is not accepted.
- Lane arithmetic, treating lane operands a and b as 4-bit two's complement:
  - s = a + b, computed in 4 bits via CLA_4bit with Cin=0.
  - Overflow occurs when a[3]==b[3] and s[3]!=a[3].
  - Positive overflow (a[3]=0) gives 4'b0111; negative overflow (a[3]=1) gives 4'b1000; otherwise s.
  - The lane saturation flag is the overflow bit.
- rd, sat and the lane bits already written are stable from one edge to the next except at the edge where a lane is written. rd and sat hold the final result after DONE until the next accepted start.
- All outputs are registered; no combinational path exists from start/rs/rt to rd, done or sat.

Test Plan:
- Basic: rs=16'h1234, rt=16'h1111, pulse start. Expect busy=1 for 5 cycles, done pulse exactly 5 cycles after start, rd=16'h2345, sat=0.
- Positive saturation: rs=16'h7777, rt=16'h1111. Expect rd=16'h7777, sat=1.
- Negative saturation: rs=16'h8888, rt=16'hFFFF. Expect rd=16'h8888 (-8 clamp in every lane), sat=1.
- Mixed lanes: rs=16'h7F81, rt=16'h1F8F. Expect lane0 0, lane1 -8, lane2 -2, lane3 +7, so rd=16'h7E80 and sat=1.
- Handshake: start held high during CALC while rs/rt change. Expect rd to reflect only the first captured operands and exactly one done. Then start in the IDLE cycle right after DONE is accepted.
- Abort/reset:
  - flush during CALC (after 2 lanes): expect IDLE next cycle, no done pulse, busy=0.
  - rst_n low mid-CALC: expect rd=0, sat=0, busy=0, done=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/paddsb_seq.sv
// paddsb_seq: multi-cycle saturating sub-word adder (PADDSB).
// The two 16-bit operands are split into four signed nibble lanes. One shared
// 4-bit CLA computes one lane per cycle. The EX stage drives the unit through a
// start/done handshake. The unit accepts one operation every six cycles.

// 4-bit carry-lookahead adder; carries come from generate/propagate terms
module cla_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s
);
    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    // lookahead carries, flattened so no carry ripples through the sum bits
    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        s    = p ^ c;
    end
endmodule

module paddsb_seq #(
    parameter int LANES  = 4,
    parameter int LANE_W = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      flush,
    input  logic [LANES*LANE_W-1:0]   rs,
    input  logic [LANES*LANE_W-1:0]   rt,
    output logic                      busy,
    output logic                      done,
    output logic                      sat,
    output logic [LANES*LANE_W-1:0]   rd
);
    localparam int W  = LANES * LANE_W;
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    // Result of one lane step: the clamped nibble and its overflow flag.
    typedef struct packed {
        logic [LANE_W-1:0] val;
        logic              ovf;
    } lane_rsp_t;

    state_t          state;
    state_t          state_nx;
    logic [LW-1:0]   lane;
    logic [W-1:0]    op_a;
    logic [W-1:0]    op_b;
    logic [LANE_W-1:0] lane_a;
    logic [LANE_W-1:0] lane_b;
    logic [LANE_W-1:0] lane_s;
    lane_rsp_t       rsp;
    logic            accept;

    assign accept = (state == IDLE) && start && !flush;

    // select the lane currently being processed from the captured operands
    always_comb begin
        lane_a = op_a[lane*LANE_W +: LANE_W];
        lane_b = op_b[lane*LANE_W +: LANE_W];
    end

    cla_4bit u_cla (
        .a   (lane_a),
        .b   (lane_b),
        .cin (1'b0),
        .s   (lane_s)
    );

    // signed overflow happens only when the inputs have the same sign and the sum's sign differs; clamp to the extreme with the input sign
    always_comb begin
        rsp.ovf = (lane_a[LANE_W-1] == lane_b[LANE_W-1]) &&
                  (lane_s[LANE_W-1] != lane_a[LANE_W-1]);
        rsp.val = rsp.ovf ? {lane_a[LANE_W-1], {(LANE_W-1){~lane_a[LANE_W-1]}}}
                          : lane_s;
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // next-state: flush wins over everything, start only honoured in IDLE
    always_comb begin
        state_nx = state;
        if (flush) begin
            state_nx = IDLE;
        end else begin
            unique case (state)
                IDLE:    if (start) state_nx = CALC;
                CALC:    if (lane == LAST_LANE) state_nx = DONE;
                DONE:    state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    // outputs decoded from the state register only
    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    // datapath: capture operands on accept, then write one lane per CALC cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane <= '0;
            op_a <= '0;
            op_b <= '0;
            rd   <= '0;
            sat  <= 1'b0;
        end else if (flush) begin
            // partial rd/sat are deliberately left as they are
            lane <= '0;
        end else if (accept) begin
            op_a <= rs;
            op_b <= rt;
            rd   <= '0;
            sat  <= 1'b0;
            lane <= '0;
        end else if (state == CALC) begin
            rd[lane*LANE_W +: LANE_W] <= rsp.val;
            sat  <= sat | rsp.ovf;
            lane <= (lane == LAST_LANE) ? '0 : lane + 1'b1;
        end
    end
endmodule

// File: tb/tb_paddsb_seq.sv
// Directed bench for paddsb_seq: lane arithmetic, latency, handshake, flush, reset.
module tb_paddsb_seq;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        flush;
    logic [15:0] rs;
    logic [15:0] rt;
    logic        busy;
    logic        done;
    logic        sat;
    logic [15:0] rd;

    int n_vec = 0;
    int n_err = 0;

    paddsb_seq #(.LANES(4), .LANE_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .flush (flush),
        .rs    (rs),
        .rt    (rt),
        .busy  (busy),
        .done  (done),
        .sat   (sat),
        .rd    (rd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Caller sits at a negedge with the unit idle. Checks rd/sat clear, busy
    // for five cycles, done in the fifth, result, and return to idle.
    task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] exp_rd, input logic exp_sat);
        rs = a; rt = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0; rs = ~a; rt = ~b;
        chk({tag, ":rd_clr"}, rd, 16'h0000);
        chk({tag, ":sat_clr"}, {15'd0, sat}, 16'd0);
        for (int k = 1; k <= 5; k++) begin
            if (k > 1) @(negedge clk);
            chk($sformatf("%s:busy%0d", tag, k), {15'd0, busy}, 16'd1);
            chk($sformatf("%s:done%0d", tag, k), {15'd0, done}, {15'd0, (k == 5)});
        end
        chk({tag, ":rd"}, rd, exp_rd);
        chk({tag, ":sat"}, {15'd0, sat}, {15'd0, exp_sat});
        @(negedge clk);
        chk({tag, ":idle_busy"}, {15'd0, busy}, 16'd0);
        chk({tag, ":idle_done"}, {15'd0, done}, 16'd0);
    endtask

    initial begin
        int ndone;
        rst_n = 1'b0; start = 1'b0; flush = 1'b0; rs = 16'h0; rt = 16'h0;
        @(negedge clk);
        chk("rst:rd", rd, 16'h0000);
        chk("rst:sat", {15'd0, sat}, 16'd0);
        chk("rst:busy", {15'd0, busy}, 16'd0);
        chk("rst:done", {15'd0, done}, 16'd0);
        rst_n = 1'b1;
        @(negedge clk);

        do_op("basic", 16'h1234, 16'h1111, 16'h2345, 1'b0);
        do_op("possat", 16'h7777, 16'h1111, 16'h7777, 1'b1);
        do_op("negsat", 16'h8888, 16'hFFFF, 16'h8888, 1'b1);
        do_op("mixed", 16'h7F81, 16'h1F8F, 16'h7E80, 1'b1);

        // start held high through the op while operands wander
        start = 1'b1; rs = 16'h1234; rt = 16'h1111; ndone = 0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (done) ndone++;
            if (k == 5) begin
                chk("hs:rd", rd, 16'h2345);
                rs = 16'h7777; rt = 16'h1111;
            end else begin
                rs = 16'($urandom); rt = 16'($urandom);
            end
        end
        @(negedge clk);
        chk("hs:one_done", 16'(ndone), 16'd1);
        chk("hs:idle", {15'd0, busy}, 16'd0);
        @(negedge clk);
        chk("hs:reaccept", {15'd0, busy}, 16'd1);
        start = 1'b0; rs = 16'h0; rt = 16'h0;
        for (int k = 2; k <= 5; k++) @(negedge clk);
        chk("hs2:done", {15'd0, done}, 16'd1);
        chk("hs2:rd", rd, 16'h7777);
        @(negedge clk);

        // flush after two lanes
        start = 1'b1; rs = 16'h1234; rt = 16'h1111;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("fl:busy", {15'd0, busy}, 16'd0);
        ndone = 0;
        for (int k = 0; k < 5; k++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        chk("fl:no_done", 16'(ndone), 16'd0);

        // flush beats start in IDLE
        start = 1'b1; flush = 1'b1; rs = 16'h1111; rt = 16'h1111;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        chk("flidle:busy", {15'd0, busy}, 16'd0);
        @(negedge clk);

        // asynchronous reset mid-CALC
        start = 1'b1; rs = 16'h7777; rt = 16'h1111;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rm:partial_rd", rd, 16'h0077);
        chk("rm:partial_sat", {15'd0, sat}, 16'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("rm:rd", rd, 16'h0000);
        chk("rm:sat", {15'd0, sat}, 16'd0);
        chk("rm:busy", {15'd0, busy}, 16'd0);
        chk("rm:done", {15'd0, done}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_op("post_rst", 16'h1234, 16'h1111, 16'h2345, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
